// File: rtl/mmio_bus_mux_if.sv
// Bus bundle between the CPU memory controller, the MMIO mux and the
// MMIO cores. The master side is the environment (CPU plus cores); the
// slave side is the mux itself.
interface mmio_bus_mux_if #(
   parameter int NUM_TARGETS = 8
);
   // CPU side
   logic                       cpu_valid;
   logic [31:0]                cpu_addr;
   logic [3:0]                 cpu_wstrb;
   logic [31:0]                cpu_wdata;
   logic                       cpu_ready;
   logic [31:0]                cpu_rdata;
   logic                       fw_app_mode;

   // Target side
   logic [NUM_TARGETS-1:0]     tgt_cs;
   logic                       tgt_we;
   logic [7:0]                 tgt_address;
   logic [31:0]                tgt_write_data;
   logic [32*NUM_TARGETS-1:0]  tgt_read_data;
   logic [NUM_TARGETS-1:0]     tgt_ready;

   // Error reporting
   logic                       err_valid;
   logic [1:0]                 err_code;
   logic [31:0]                err_addr;
   logic [7:0]                 err_count;

   modport master (
      output cpu_valid, cpu_addr, cpu_wstrb, cpu_wdata, fw_app_mode,
      output tgt_read_data, tgt_ready,
      input  cpu_ready, cpu_rdata,
      input  tgt_cs, tgt_we, tgt_address, tgt_write_data,
      input  err_valid, err_code, err_addr, err_count
   );

   modport slave (
      input  cpu_valid, cpu_addr, cpu_wstrb, cpu_wdata, fw_app_mode,
      input  tgt_read_data, tgt_ready,
      output cpu_ready, cpu_rdata,
      output tgt_cs, tgt_we, tgt_address, tgt_write_data,
      output err_valid, err_code, err_addr, err_count
   );
endinterface

// File: rtl/mmio_bus_mux.sv
// MMIO interconnect: routes one CPU access at a time to the core whose
// 6-bit prefix matches cpu_addr[29:24], with a ready timeout, app-mode
// write protection and error reporting with a saturating error counter.
module mmio_bus_mux #(
   parameter int                       NUM_TARGETS    = 8,
   parameter logic [6*NUM_TARGETS-1:0] TGT_PREFIXES   = {NUM_TARGETS{6'h3f}},
   parameter logic [NUM_TARGETS-1:0]   APP_WP_MASK    = '0,
   parameter int                       TIMEOUT_CYCLES = 255
) (
   input logic           clk,
   input logic           reset_n,
   mmio_bus_mux_if.slave bus
);

   localparam int          IDX_W    = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } state_t;

   state_t           state;
   logic [IDX_W-1:0] sel_idx;
   logic [15:0]      tmo_cnt;
   logic [31:0]      lat_addr;

   logic             hit;
   logic [IDX_W-1:0] hit_idx;

   // Error counter sticks at its maximum instead of wrapping.
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hff) ? v : v + 8'd1;
   endfunction

   // Prefix decode; scanning from the top down lets the lowest matching index win.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = NUM_TARGETS - 1; i >= 0; i--) begin
         if (bus.cpu_addr[29:24] == TGT_PREFIXES[6*i +: 6]) begin
            hit     = 1'b1;
            hit_idx = IDX_W'(i);
         end
      end
   end

   // Access FSM with all bus and error outputs registered.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state              <= IDLE;
         sel_idx            <= '0;
         tmo_cnt            <= '0;
         lat_addr           <= '0;
         bus.cpu_ready      <= 1'b0;
         bus.cpu_rdata      <= '0;
         bus.tgt_cs         <= '0;
         bus.tgt_we         <= 1'b0;
         bus.tgt_address    <= '0;
         bus.tgt_write_data <= '0;
         bus.err_valid      <= 1'b0;
         bus.err_code       <= 2'd0;
         bus.err_addr       <= '0;
         bus.err_count      <= '0;
      end else begin
         bus.cpu_ready <= 1'b0;
         bus.err_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.cpu_valid) begin
                  lat_addr           <= bus.cpu_addr;
                  bus.tgt_we         <= |bus.cpu_wstrb;
                  bus.tgt_address    <= bus.cpu_addr[9:2];
                  bus.tgt_write_data <= bus.cpu_wdata;
                  if (!hit) begin
                     bus.cpu_rdata <= '0;
                     bus.cpu_ready <= 1'b1;
                     bus.err_valid <= 1'b1;
                     bus.err_code  <= 2'd1;
                     bus.err_addr  <= bus.cpu_addr;
                     bus.err_count <= sat_inc8(bus.err_count);
                     state         <= RESP;
                  end else if (APP_WP_MASK[hit_idx] && bus.fw_app_mode &&
                               (bus.cpu_wstrb != 4'h0)) begin
                     bus.cpu_rdata <= '0;
                     bus.cpu_ready <= 1'b1;
                     bus.err_valid <= 1'b1;
                     bus.err_code  <= 2'd2;
                     bus.err_addr  <= bus.cpu_addr;
                     bus.err_count <= sat_inc8(bus.err_count);
                     state         <= RESP;
                  end else begin
                     sel_idx    <= hit_idx;
                     tmo_cnt    <= '0;
                     bus.tgt_cs <= NUM_TARGETS'(1) << hit_idx;
                     state      <= ACCESS;
                  end
               end
            end
            ACCESS: begin
               // Ready is checked first so a late ready on the last cycle still returns data.
               if (bus.tgt_ready[sel_idx]) begin
                  bus.cpu_rdata <= bus.tgt_read_data[32*sel_idx +: 32];
                  bus.cpu_ready <= 1'b1;
                  bus.tgt_cs    <= '0;
                  state         <= RESP;
               end else if (tmo_cnt == TMO_LAST) begin
                  bus.cpu_rdata <= '0;
                  bus.cpu_ready <= 1'b1;
                  bus.tgt_cs    <= '0;
                  bus.err_valid <= 1'b1;
                  bus.err_code  <= 2'd3;
                  bus.err_addr  <= lat_addr;
                  bus.err_count <= sat_inc8(bus.err_count);
                  state         <= RESP;
               end else begin
                  tmo_cnt <= tmo_cnt + 16'd1;
               end
            end
            RESP: begin
               // cpu_valid is deliberately ignored here to avoid accepting the same request twice.
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mmio_bus_mux.sv
// Self-checking bench for mmio_bus_mux: two targets (prefixes 0x00, 0x01),
// target 1 write-protected in app mode, timeout of 4 cycles.
`timescale 1ns/1ps
module tb_mmio_bus_mux;
   localparam int          NT  = 2;
   localparam logic [11:0] PFX = {6'h01, 6'h00};
   localparam logic [1:0]  WP  = 2'b10;
   localparam int          TMO = 4;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   mmio_bus_mux_if #(.NUM_TARGETS(NT)) bus ();

   mmio_bus_mux #(
      .NUM_TARGETS(NT), .TGT_PREFIXES(PFX), .APP_WP_MASK(WP), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Target behaviour: dly = 0 means ready tied high; otherwise ready once cs has been held dly cycles.
   int          dly   [NT];
   int          age   [NT];
   logic [31:0] tdata [NT];

   logic [5:0] pfx_tab [NT] = '{6'h00, 6'h01};
   logic       wp_tab  [NT] = '{1'b0, 1'b1};

   always_ff @(posedge clk) begin
      for (int i = 0; i < NT; i++) age[i] <= bus.tgt_cs[i] ? age[i] + 1 : 0;
   end

   always_comb begin
      bus.tgt_ready     = '0;
      bus.tgt_read_data = '0;
      for (int i = 0; i < NT; i++) begin
         bus.tgt_read_data[32*i +: 32] = tdata[i];
         bus.tgt_ready[i] = (dly[i] == 0) || (bus.tgt_cs[i] && (age[i] >= dly[i]));
      end
   end

   typedef struct {
      int          lat;
      int          cs_cycles;
      int          tgt;
      logic [31:0] rdata;
      logic [1:0]  code;
   } exp_t;

   typedef struct {
      int          lat;
      int          cs_cycles;
      int          cs_first;
      logic [NT-1:0] cs_seen;
      logic        multi;
      logic        we;
      logic [7:0]  taddr;
      logic [31:0] twd;
      logic [31:0] rdata;
      logic        ev;
      logic [1:0]  ec;
      logic [31:0] ea;
      logic [7:0]  cnt;
      logic        ready_after;
   } obs_t;

   // Expected persistent error state.
   logic [1:0]  exp_ec  = 2'd0;
   logic [31:0] exp_ea  = '0;
   int          exp_cnt = 0;

   // Reference: outcome of one access from the decode/protect/timeout rules.
   function automatic exp_t model(input logic [31:0] a, input logic [3:0] ws, input logic app);
      exp_t e;
      int   idx;
      idx = -1;
      e.tgt = -1; e.rdata = '0; e.code = 2'd0; e.cs_cycles = 0; e.lat = 1;
      for (int i = 0; i < NT; i++) if (idx < 0 && a[29:24] == pfx_tab[i]) idx = i;
      if (idx < 0) e.code = 2'd1;
      else if (wp_tab[idx] && app && ws != 4'h0) e.code = 2'd2;
      else begin
         e.tgt = idx;
         if (dly[idx] < TMO) begin
            e.cs_cycles = dly[idx] + 1;
            e.rdata     = tdata[idx];
         end else begin
            e.cs_cycles = TMO;
            e.code      = 2'd3;
         end
         e.lat = e.cs_cycles + 1;
      end
      return e;
   endfunction

   task automatic model_commit(input exp_t e, input logic [31:0] a);
      if (e.code != 2'd0) begin
         exp_ec = e.code;
         exp_ea = a;
         if (exp_cnt < 255) exp_cnt++;
      end
   endtask

   // Drives one access and records what the DUT did, cycle by cycle.
   task automatic run_access(input logic [31:0] a, input logic [3:0] ws, input logic [31:0] wd,
                             input logic app, output obs_t o);
      o.lat = -1; o.cs_cycles = 0; o.cs_first = -1; o.cs_seen = '0; o.multi = 1'b0;
      o.we = 1'b0; o.taddr = '0; o.twd = '0; o.rdata = '0; o.ev = 1'b0; o.ec = '0;
      o.ea = '0; o.cnt = '0; o.ready_after = 1'b0;
      @(posedge clk); #1;
      bus.cpu_valid = 1'b1; bus.cpu_addr = a; bus.cpu_wstrb = ws; bus.cpu_wdata = wd;
      bus.fw_app_mode = app;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk); #1;
         if (bus.tgt_cs != '0) begin
            if (o.cs_first < 0) begin
               o.cs_first = n; o.we = bus.tgt_we; o.taddr = bus.tgt_address;
               o.twd = bus.tgt_write_data;
            end
            o.cs_cycles++;
            o.cs_seen |= bus.tgt_cs;
            if ($countones(bus.tgt_cs) != 1) o.multi = 1'b1;
         end
         if (bus.cpu_ready) begin
            o.lat = n; o.rdata = bus.cpu_rdata; o.ev = bus.err_valid; o.ec = bus.err_code;
            o.ea = bus.err_addr; o.cnt = bus.err_count;
            break;
         end
      end
      bus.cpu_valid = 1'b0;
      @(posedge clk); #1;
      o.ready_after = bus.cpu_ready;
   endtask

   task automatic test_reset();
      bus.cpu_valid = 1'b0; bus.cpu_addr = '0; bus.cpu_wstrb = '0; bus.cpu_wdata = '0;
      bus.fw_app_mode = 1'b0;
      for (int i = 0; i < NT; i++) begin dly[i] = 99; tdata[i] = '0; end
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if ({bus.cpu_ready, bus.tgt_cs, bus.tgt_we, bus.err_valid, bus.err_code} !== '0) begin
         n_bad++; $display("FAIL reset_ctrl: got rdy=%b cs=%b we=%b ev=%b ec=%0d want all 0",
                           bus.cpu_ready, bus.tgt_cs, bus.tgt_we, bus.err_valid, bus.err_code); end
      n_cmp++; if ({bus.cpu_rdata, bus.tgt_write_data, bus.err_addr} !== '0) begin
         n_bad++; $display("FAIL reset_data: got rdata=%h twd=%h ea=%h want 0",
                           bus.cpu_rdata, bus.tgt_write_data, bus.err_addr); end
      n_cmp++; if ({bus.tgt_address, bus.err_count} !== '0) begin
         n_bad++; $display("FAIL reset_addr_cnt: got taddr=%h cnt=%0d want 0", bus.tgt_address, bus.err_count); end
      reset_n = 1'b1;
   endtask

   task automatic test_basic_read();
      obs_t o; exp_t e;
      dly[0] = 0; dly[1] = 99; tdata[0] = 32'h1234_5678;
      e = model(32'hC000_0010, 4'h0, 1'b0);
      run_access(32'hC000_0010, 4'h0, 32'h0, 1'b0, o);
      model_commit(e, 32'hC000_0010);
      n_cmp++; if (o.cs_first !== 1 || o.cs_seen !== 2'b01) begin n_bad++;
         $display("FAIL read_cs: got first=%0d cs=%b want 1 / 01", o.cs_first, o.cs_seen); end
      n_cmp++; if (o.taddr !== 8'h04) begin n_bad++;
         $display("FAIL read_addr: got %h want 04", o.taddr); end
      n_cmp++; if (o.lat !== 2 || o.rdata !== 32'h1234_5678) begin n_bad++;
         $display("FAIL read_resp: got lat=%0d rdata=%h want 2 / 12345678", o.lat, o.rdata); end
      n_cmp++; if (o.ev !== 1'b0 || o.ready_after !== 1'b0) begin n_bad++;
         $display("FAIL read_flags: got ev=%b ready_next=%b want 0 / 0", o.ev, o.ready_after); end
   endtask

   task automatic test_unmapped();
      obs_t o; exp_t e;
      e = model(32'hFA00_0000, 4'hF, 1'b0);
      run_access(32'hFA00_0000, 4'hF, 32'hCAFE_F00D, 1'b0, o);
      model_commit(e, 32'hFA00_0000);
      n_cmp++; if (o.cs_seen !== 2'b00 || o.lat !== 1 || o.rdata !== 32'h0) begin n_bad++;
         $display("FAIL unmapped_resp: got cs=%b lat=%0d rdata=%h want 00 / 1 / 0", o.cs_seen, o.lat, o.rdata); end
      n_cmp++; if (o.ev !== 1'b1 || o.ec !== 2'd1 || o.ea !== 32'hFA00_0000 || o.cnt !== 8'd1) begin n_bad++;
         $display("FAIL unmapped_err: got ev=%b ec=%0d ea=%h cnt=%0d want 1 / 1 / fa000000 / 1",
                  o.ev, o.ec, o.ea, o.cnt); end
   endtask

   task automatic test_write_protect();
      obs_t o; exp_t e;
      dly[1] = 0;
      e = model(32'hC100_0000, 4'hF, 1'b1);
      run_access(32'hC100_0000, 4'hF, 32'hDEAD_BEEF, 1'b1, o);
      model_commit(e, 32'hC100_0000);
      n_cmp++; if (o.cs_seen !== 2'b00 || o.lat !== 1 || o.ec !== 2'd2 || o.ev !== 1'b1 || o.cnt !== 8'd2) begin n_bad++;
         $display("FAIL wp_app_write: got cs=%b lat=%0d ev=%b ec=%0d cnt=%0d want 00 / 1 / 1 / 2 / 2",
                  o.cs_seen, o.lat, o.ev, o.ec, o.cnt); end
      e = model(32'hC100_0000, 4'hF, 1'b0);
      run_access(32'hC100_0000, 4'hF, 32'hDEAD_BEEF, 1'b0, o);
      model_commit(e, 32'hC100_0000);
      n_cmp++; if (o.cs_seen !== 2'b10 || o.we !== 1'b1 || o.twd !== 32'hDEAD_BEEF || o.lat !== 2) begin n_bad++;
         $display("FAIL wp_fw_write: got cs=%b we=%b wd=%h lat=%0d want 10 / 1 / deadbeef / 2",
                  o.cs_seen, o.we, o.twd, o.lat); end
      n_cmp++; if (o.ev !== 1'b0 || o.ec !== 2'd2) begin n_bad++;
         $display("FAIL wp_fw_errhold: got ev=%b ec=%0d want 0 / 2", o.ev, o.ec); end
      run_access(32'hC100_0004, 4'h0, 32'h0, 1'b1, o);
      n_cmp++; if (o.cs_seen !== 2'b10 || o.we !== 1'b0 || o.ev !== 1'b0) begin n_bad++;
         $display("FAIL wp_app_read: got cs=%b we=%b ev=%b want 10 / 0 / 0", o.cs_seen, o.we, o.ev); end
   endtask

   task automatic test_timeout();
      obs_t o; exp_t e;
      dly[1] = 99; tdata[1] = 32'h5555_AAAA;
      e = model(32'hC100_0008, 4'h0, 1'b0);
      run_access(32'hC100_0008, 4'h0, 32'h0, 1'b0, o);
      model_commit(e, 32'hC100_0008);
      n_cmp++; if (o.cs_cycles !== 4 || o.lat !== 5 || o.rdata !== 32'h0) begin n_bad++;
         $display("FAIL timeout_resp: got cs_cycles=%0d lat=%0d rdata=%h want 4 / 5 / 0", o.cs_cycles, o.lat, o.rdata); end
      n_cmp++; if (o.ev !== 1'b1 || o.ec !== 2'd3 || o.ea !== 32'hC100_0008 || o.cnt !== 8'd3) begin n_bad++;
         $display("FAIL timeout_err: got ev=%b ec=%0d ea=%h cnt=%0d want 1 / 3 / c1000008 / 3",
                  o.ev, o.ec, o.ea, o.cnt); end
   endtask

   task automatic test_ready_at_timeout();
      obs_t o; exp_t e;
      dly[0] = TMO - 1; tdata[0] = 32'hA5A5_0F0F;
      e = model(32'hC000_0020, 4'h0, 1'b0);
      run_access(32'hC000_0020, 4'h0, 32'h0, 1'b0, o);
      model_commit(e, 32'hC000_0020);
      n_cmp++; if (o.cs_cycles !== 4 || o.lat !== 5 || o.rdata !== 32'hA5A5_0F0F) begin n_bad++;
         $display("FAIL late_ready_resp: got cs_cycles=%0d lat=%0d rdata=%h want 4 / 5 / a5a50f0f",
                  o.cs_cycles, o.lat, o.rdata); end
      n_cmp++; if (o.ev !== 1'b0 || o.ec !== 2'd3 || o.cnt !== 8'd3) begin n_bad++;
         $display("FAIL late_ready_err: got ev=%b ec=%0d cnt=%0d want 0 / 3 / 3", o.ev, o.ec, o.cnt); end
   endtask

   task automatic test_random();
      obs_t o; exp_t e;
      logic [31:0] a, wd; logic [3:0] ws; logic app; logic [5:0] p; logic [NT-1:0] ecs;
      for (int k = 0; k < 60; k++) begin
         case ($urandom_range(0, 3))
            0: p = 6'h00;
            1: p = 6'h01;
            2: p = 6'h3a;
            default: p = 6'($urandom);
         endcase
         a   = {2'b11, p, 14'($urandom), 8'($urandom), 2'b00};
         ws  = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
         wd  = $urandom;
         app = 1'($urandom);
         for (int i = 0; i < NT; i++) begin dly[i] = $urandom_range(0, 5); tdata[i] = $urandom; end
         e = model(a, ws, app);
         run_access(a, ws, wd, app, o);
         model_commit(e, a);
         ecs = (e.tgt < 0) ? '0 : NT'(1 << e.tgt);
         n_cmp++; if (o.lat !== e.lat || o.cs_cycles !== e.cs_cycles || o.cs_seen !== ecs || o.multi !== 1'b0) begin
            n_bad++; $display("FAIL rnd%0d_flow: addr=%h got lat=%0d cs_cycles=%0d cs=%b want %0d / %0d / %b",
                              k, a, o.lat, o.cs_cycles, o.cs_seen, e.lat, e.cs_cycles, ecs); end
         n_cmp++; if (o.rdata !== e.rdata || o.ev !== (e.code != 2'd0)) begin
            n_bad++; $display("FAIL rnd%0d_resp: got rdata=%h ev=%b want %h / %b", k, o.rdata, o.ev, e.rdata, e.code != 2'd0); end
         n_cmp++; if (o.ec !== exp_ec || o.ea !== exp_ea || o.cnt !== 8'(exp_cnt)) begin
            n_bad++; $display("FAIL rnd%0d_err: got ec=%0d ea=%h cnt=%0d want %0d / %h / %0d",
                              k, o.ec, o.ea, o.cnt, exp_ec, exp_ea, exp_cnt); end
         if (e.tgt >= 0) begin
            n_cmp++; if (o.we !== (ws != 4'h0) || o.taddr !== a[9:2] || o.twd !== wd) begin
               n_bad++; $display("FAIL rnd%0d_tgt: got we=%b addr=%h wd=%h want %b / %h / %h",
                                 k, o.we, o.taddr, o.twd, ws != 4'h0, a[9:2], wd); end
         end
      end
   endtask

   task automatic test_saturation();
      obs_t o; exp_t e;
      dly[1] = 99;
      for (int k = 0; k < 300; k++) begin
         e = model(32'hC100_0010, 4'h0, 1'b0);
         run_access(32'hC100_0010, 4'h0, 32'h0, 1'b0, o);
         model_commit(e, 32'hC100_0010);
         n_cmp++; if (o.cnt !== 8'(exp_cnt) || o.ec !== 2'd3) begin n_bad++;
            $display("FAIL sat%0d: got cnt=%0d ec=%0d want %0d / 3", k, o.cnt, o.ec, exp_cnt); end
      end
      n_cmp++; if (o.cnt !== 8'd255) begin n_bad++;
         $display("FAIL sat_final: got cnt=%0d want 255", o.cnt); end
   endtask

   task automatic test_reset_abort();
      obs_t o; exp_t e;
      dly[1] = 99;
      @(posedge clk); #1;
      bus.cpu_valid = 1'b1; bus.cpu_addr = 32'hC100_0000; bus.cpu_wstrb = 4'h0; bus.fw_app_mode = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (bus.tgt_cs !== 2'b10) begin n_bad++;
         $display("FAIL abort_pre_cs: got %b want 10", bus.tgt_cs); end
      reset_n = 1'b0;
      @(posedge clk); #1;
      n_cmp++; if (bus.tgt_cs !== 2'b00 || bus.cpu_ready !== 1'b0 || bus.err_valid !== 1'b0 || bus.err_count !== 8'd0) begin
         n_bad++; $display("FAIL abort_reset: got cs=%b rdy=%b ev=%b cnt=%0d want 00 / 0 / 0 / 0",
                           bus.tgt_cs, bus.cpu_ready, bus.err_valid, bus.err_count); end
      reset_n = 1'b1; bus.cpu_valid = 1'b0;
      exp_ec = 2'd0; exp_ea = '0; exp_cnt = 0;
      dly[1] = 1; tdata[1] = $urandom;
      e = model(32'hC100_0004, 4'h0, 1'b0);
      run_access(32'hC100_0004, 4'h0, 32'h0, 1'b0, o);
      model_commit(e, 32'hC100_0004);
      n_cmp++; if (o.cs_cycles !== 2 || o.lat !== 3 || o.rdata !== tdata[1] || o.ev !== 1'b0 || o.cnt !== 8'd0) begin
         n_bad++; $display("FAIL abort_after: got cs_cycles=%0d lat=%0d rdata=%h ev=%b cnt=%0d want 2 / 3 / %h / 0 / 0",
                           o.cs_cycles, o.lat, o.rdata, o.ev, o.cnt, tdata[1]); end
   endtask

   initial begin
      test_reset();
      test_basic_read();
      test_unmapped();
      test_write_protect();
      test_timeout();
      test_ready_at_timeout();
      test_random();
      test_saturation();
      test_reset_abort();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog expired");
   end
endmodule
